// File: rtl/memory_pipe.sv
// memory_pipe -- Y86-64 memory stage.
//
// Holds the M pipeline register, accesses an internal byte-addressed data
// RAM (8-byte little-endian words), and drives the W pipeline register.
//
// Parameters:
//   MEM_BYTES          data-memory size in bytes (power of two, >= 16)
// Optional feature macro:
//   MEM_ALIGN_CHECK_EN when defined, any access with addr[2:0] != 0 raises
//                      a memory error (SADR, no write)
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   M_bubble_i, W_stall_i     pipeline control from the hazard unit
//   e_stat_i .. e_dstM_i      execute-stage results loaded into M
//   M_icode_o .. M_dstM_o     M register contents (forwarding/control)
//   m_valM_o, m_stat_o        combinational read data and stage status
//   W_stat_o .. W_dstM_o      W register contents

module memory_pipe #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        M_bubble_i,
  input  logic        W_stall_i,
  input  logic [2:0]  e_stat_i,
  input  logic [3:0]  e_icode_i,
  input  logic        e_Cnd_i,
  input  logic [63:0] e_valE_i,
  input  logic [63:0] e_valA_i,
  input  logic [3:0]  e_dstE_i,
  input  logic [3:0]  e_dstM_i,
  output logic [3:0]  M_icode_o,
  output logic        M_Cnd_o,
  output logic [63:0] M_valE_o,
  output logic [63:0] M_valA_o,
  output logic [3:0]  M_dstE_o,
  output logic [3:0]  M_dstM_o,
  output logic [63:0] m_valM_o,
  output logic [2:0]  m_stat_o,
  output logic [2:0]  W_stat_o,
  output logic [3:0]  W_icode_o,
  output logic [63:0] W_valE_o,
  output logic [63:0] W_valM_o,
  output logic [3:0]  W_dstE_o,
  output logic [3:0]  W_dstM_o
);

  localparam int unsigned AW       = $clog2(MEM_BYTES);
  localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

  localparam logic [2:0] SAOK    = 3'd1;
  localparam logic [2:0] SADR    = 3'd3;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;

  logic [2:0]    m_stat_q;
  logic          mem_read;
  logic          mem_write;
  logic [63:0]   mem_addr;
  logic          dmem_error;
  logic [AW-1:0] base;
  logic [63:0]   rd_word;
  logic [7:0]    mem [MEM_BYTES];

  // M register: reset and bubble both insert a nop; a failed conditional
  // move keeps its destination from being written.
  always_ff @(posedge clk_i) begin
    if (rst_i || M_bubble_i) begin
      m_stat_q  <= SAOK;
      M_icode_o <= INOP;
      M_Cnd_o   <= 1'b0;
      M_valE_o  <= '0;
      M_valA_o  <= '0;
      M_dstE_o  <= RNONE;
      M_dstM_o  <= RNONE;
    end else begin
      m_stat_q  <= e_stat_i;
      M_icode_o <= e_icode_i;
      M_Cnd_o   <= e_Cnd_i;
      M_valE_o  <= e_valE_i;
      M_valA_o  <= e_valA_i;
      M_dstE_o  <= (e_icode_i == IRRMOVQ && !e_Cnd_i) ? RNONE : e_dstE_i;
      M_dstM_o  <= e_dstM_i;
    end
  end

  // Access decode; the range check is a full 64-bit unsigned compare so
  // negative and wrapped addresses are rejected too.
  always_comb begin
    mem_read  = (M_icode_o == IMRMOVQ) || (M_icode_o == IPOPQ) || (M_icode_o == IRET);
    mem_write = (M_icode_o == IRMMOVQ) || (M_icode_o == IPUSHQ) || (M_icode_o == ICALL);
    mem_addr  = (M_icode_o == IPOPQ || M_icode_o == IRET) ? M_valA_o : M_valE_o;
`ifdef MEM_ALIGN_CHECK_EN
    dmem_error = (mem_read || mem_write) &&
                 ((mem_addr > ADDR_MAX) || (mem_addr[2:0] != 3'b000));
`else
    dmem_error = (mem_read || mem_write) && (mem_addr > ADDR_MAX);
`endif
    base = mem_addr[AW-1:0];
    rd_word = '0;
    for (int i = 0; i < 8; i++) begin
      rd_word[8*i +: 8] = mem[base + AW'(i)];
    end
    m_valM_o = (mem_read && !dmem_error) ? rd_word : 64'd0;
    m_stat_o = dmem_error ? SADR : m_stat_q;
  end

  // RAM is not reset; a store sitting in M while reset is high is dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_i && mem_write && !dmem_error) begin
      for (int i = 0; i < 8; i++) begin
        mem[base + AW'(i)] <= M_valA_o[8*i +: 8];
      end
    end
  end

  // W register: captures the pre-bubble M contents; stall only freezes W.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      W_stat_o  <= SAOK;
      W_icode_o <= INOP;
      W_valE_o  <= '0;
      W_valM_o  <= '0;
      W_dstE_o  <= RNONE;
      W_dstM_o  <= RNONE;
    end else if (!W_stall_i) begin
      W_stat_o  <= m_stat_o;
      W_icode_o <= M_icode_o;
      W_valE_o  <= M_valE_o;
      W_valM_o  <= m_valM_o;
      W_dstE_o  <= M_dstE_o;
      W_dstM_o  <= M_dstM_o;
    end
  end

endmodule

// File: tb/tb_memory_pipe.sv
// tb_memory_pipe -- self-checking bench for memory_pipe.
// Directed table vectors plus hand-written multi-cycle sequences, then a
// randomized phase; every cycle is compared against a reference model that
// keeps the RAM as a plain byte array and the M/W registers as structs.

module tb_memory_pipe;

  localparam int unsigned MEM_BYTES = 1024;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } m_t;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } w_t;

  typedef struct {
    string       name;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  exp_dstE;
    logic [2:0]  exp_mstat;
  } vec_t;

  localparam m_t M_BUB = '{3'd1, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF};
  localparam w_t W_BUB = '{3'd1, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF};

  logic        clk_i = 1'b0;
  logic        rst_i, M_bubble_i, W_stall_i, e_Cnd_i;
  logic [2:0]  e_stat_i;
  logic [3:0]  e_icode_i, e_dstE_i, e_dstM_i;
  logic [63:0] e_valE_i, e_valA_i;
  logic [3:0]  M_icode_o, M_dstE_o, M_dstM_o, W_icode_o, W_dstE_o, W_dstM_o;
  logic        M_Cnd_o;
  logic [63:0] M_valE_o, M_valA_o, m_valM_o, W_valE_o, W_valM_o;
  logic [2:0]  m_stat_o, W_stat_o;

  m_t         ref_m = M_BUB;
  w_t         ref_w = W_BUB;
  logic [7:0] ref_mem [MEM_BYTES];
  int         checks = 0;
  int         errors = 0;
  vec_t       vecs [10];
  w_t         saved_w;

  memory_pipe #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .M_bubble_i(M_bubble_i), .W_stall_i(W_stall_i),
    .e_stat_i(e_stat_i), .e_icode_i(e_icode_i), .e_Cnd_i(e_Cnd_i),
    .e_valE_i(e_valE_i), .e_valA_i(e_valA_i), .e_dstE_i(e_dstE_i), .e_dstM_i(e_dstM_i),
    .M_icode_o(M_icode_o), .M_Cnd_o(M_Cnd_o), .M_valE_o(M_valE_o), .M_valA_o(M_valA_o),
    .M_dstE_o(M_dstE_o), .M_dstM_o(M_dstM_o), .m_valM_o(m_valM_o), .m_stat_o(m_stat_o),
    .W_stat_o(W_stat_o), .W_icode_o(W_icode_o), .W_valE_o(W_valE_o), .W_valM_o(W_valM_o),
    .W_dstE_o(W_dstE_o), .W_dstM_o(W_dstM_o)
  );

  always #5 clk_i = ~clk_i;

  // What the instruction held in M does to memory, from the ISA rules.
  function automatic void memResult(input m_t m, output logic [2:0] stat,
                                    output logic [63:0] valm, output logic wr_ok,
                                    output int addr_i);
    logic        rd, wr, bad;
    logic [63:0] addr;
    rd   = (m.icode == 4'h5) || (m.icode == 4'hB) || (m.icode == 4'h9);
    wr   = (m.icode == 4'h4) || (m.icode == 4'hA) || (m.icode == 4'h8);
    addr = (m.icode == 4'hB || m.icode == 4'h9) ? m.valA : m.valE;
    bad  = (rd || wr) && (addr > 64'(MEM_BYTES - 8));
`ifdef MEM_ALIGN_CHECK_EN
    bad  = bad || ((rd || wr) && (addr % 64'd8 != 64'd0));
`endif
    addr_i = bad ? 0 : int'(addr);
    valm = 64'd0;
    if (rd && !bad)
      for (int i = 0; i < 8; i++) valm = valm | (64'(ref_mem[addr_i + i]) << (8 * i));
    stat  = bad ? 3'd3 : m.stat;
    wr_ok = wr && !bad;
  endfunction

  task automatic modelEdge();
    logic [2:0]  st;
    logic [63:0] vm;
    logic        wok;
    int          a;
    memResult(ref_m, st, vm, wok, a);
    if (!rst_i && wok)
      for (int i = 0; i < 8; i++) ref_mem[a + i] = ref_m.valA[8*i +: 8];
    if (rst_i) ref_w = W_BUB;
    else if (!W_stall_i) ref_w = '{st, ref_m.icode, ref_m.valE, vm, ref_m.dstE, ref_m.dstM};
    if (rst_i || M_bubble_i) ref_m = M_BUB;
    else ref_m = '{e_stat_i, e_icode_i, e_Cnd_i, e_valE_i, e_valA_i,
                   (e_icode_i == 4'h2 && !e_Cnd_i) ? 4'hF : e_dstE_i, e_dstM_i};
  endtask

  task automatic checkValue(input string name, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic checkOutput(input string name);
    logic [2:0]  st;
    logic [63:0] vm;
    logic        wok;
    int          a;
    memResult(ref_m, st, vm, wok, a);
    checkValue({name, " Mreg"},
      192'({M_icode_o, M_Cnd_o, M_valE_o, M_valA_o, M_dstE_o, M_dstM_o}),
      192'({ref_m.icode, ref_m.cnd, ref_m.valE, ref_m.valA, ref_m.dstE, ref_m.dstM}));
    checkValue({name, " mstage"}, 192'({m_stat_o, m_valM_o}), 192'({st, vm}));
    checkValue({name, " Wreg"},
      192'({W_stat_o, W_icode_o, W_valE_o, W_valM_o, W_dstE_o, W_dstM_o}), 192'(ref_w));
  endtask

  task automatic applyStimulus(input logic [3:0] icode, input logic cnd,
                               input logic [63:0] valE, input logic [63:0] valA,
                               input logic [3:0] dstE, input logic [3:0] dstM,
                               input logic [2:0] stat, input logic bubble,
                               input logic stall, input logic rst);
    e_icode_i = icode; e_Cnd_i = cnd; e_valE_i = valE; e_valA_i = valA;
    e_dstE_i = dstE; e_dstM_i = dstM; e_stat_i = stat;
    M_bubble_i = bubble; W_stall_i = stall; rst_i = rst;
  endtask

  task automatic step(input string name);
    @(posedge clk_i);
    modelEdge();
    #1;
    checkOutput(name);
  endtask

  function automatic logic [63:0] randAddr();
    int unsigned r;
    r = $urandom_range(0, 99);
    if (r < 70) return 64'({$urandom_range(0, MEM_BYTES / 8 - 1), 3'b000});
    if (r < 85) return 64'($urandom_range(0, MEM_BYTES - 1));
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    vecs[0] = '{"cmov_fail", 4'h2, 1'b0, 64'd5, 64'd6, 4'h3, 4'hF, 3'd1};
    vecs[1] = '{"cmov_taken", 4'h2, 1'b1, 64'd5, 64'd6, 4'h3, 4'h3, 3'd1};
    vecs[2] = '{"opq_cnd0", 4'h6, 1'b0, 64'd7, 64'd0, 4'h5, 4'h5, 3'd1};
    vecs[3] = '{"push_oor", 4'hA, 1'b0, 64'(MEM_BYTES - 4), 64'h55, 4'h4, 4'h4, 3'd3};
    vecs[4] = '{"pop_neg", 4'hB, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 4'h4, 4'h4, 3'd3};
`ifdef MEM_ALIGN_CHECK_EN
    vecs[5] = '{"load_0x13", 4'h5, 1'b0, 64'h13, 64'd0, 4'hF, 4'hF, 3'd3};
`else
    vecs[5] = '{"load_0x13", 4'h5, 1'b0, 64'h13, 64'd0, 4'hF, 4'hF, 3'd1};
`endif
    vecs[6] = '{"load_top", 4'h5, 1'b0, 64'(MEM_BYTES - 8), 64'd0, 4'hF, 4'hF, 3'd1};
    vecs[7] = '{"load_top+1", 4'h5, 1'b0, 64'(MEM_BYTES - 7), 64'd0, 4'hF, 4'hF, 3'd3};
    vecs[8] = '{"ret_zero", 4'h9, 1'b0, 64'd8, 64'd0, 4'h4, 4'h4, 3'd1};
    vecs[9] = '{"store_neg", 4'h4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1, 4'hF, 4'hF, 3'd3};

    applyStimulus(4'h1, 0, 0, 0, 4'hF, 4'hF, 3'd1, 0, 0, 1);
    step("reset");
    checkValue("reset M_icode", 192'(M_icode_o), 192'(4'h1));
    checkValue("reset W_icode/stat", 192'({W_icode_o, W_stat_o}), 192'({4'h1, 3'd1}));
    checkValue("reset dsts", 192'({M_dstE_o, M_dstM_o, W_dstE_o, W_dstM_o}), 192'(16'hFFFF));
    checkValue("reset valM", 192'(m_valM_o), 192'(0));

    for (int a = 0; a < MEM_BYTES; a += 8) begin
      applyStimulus(4'h4, 0, 64'(a), {$urandom(), $urandom()}, 4'hF, 4'hF, 3'd1, 0, 0, 0);
      step("fill");
    end

    applyStimulus(4'h4, 0, 64'h10, 64'h1122_3344_5566_7788, 4'hF, 4'hF, 3'd1, 0, 0, 0);
    step("st_0x10");
    applyStimulus(4'h5, 0, 64'h10, 0, 4'hF, 4'h2, 3'd1, 0, 0, 0);
    step("ld_0x10");
    checkValue("raw valM", 192'(m_valM_o), 192'(64'h1122_3344_5566_7788));
    checkValue("byte 0x10", 192'(m_valM_o[7:0]), 192'(8'h88));
    applyStimulus(4'h1, 0, 0, 0, 4'hF, 4'hF, 3'd1, 0, 0, 0);
    step("nop");
    checkValue("W_valM load", 192'(W_valM_o), 192'(64'h1122_3344_5566_7788));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].icode, vecs[i].cnd, vecs[i].valE, vecs[i].valA,
                    vecs[i].dstE, 4'hF, 3'd1, 0, 0, 0);
      step(vecs[i].name);
      checkValue({vecs[i].name, " dstE"}, 192'(M_dstE_o), 192'(vecs[i].exp_dstE));
      checkValue({vecs[i].name, " m_stat"}, 192'(m_stat_o), 192'(vecs[i].exp_mstat));
    end
    applyStimulus(4'h5, 0, 64'(MEM_BYTES - 8), 0, 4'hF, 4'h1, 3'd1, 0, 0, 0);
    step("readback_top");

    saved_w = ref_w;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(4'h6, 1, 64'(100 + k), 64'(k), 4'h1, 4'hF, 3'd1, 0, 1, 0);
      step("w_stall");
      checkValue("W held", 192'({W_stat_o, W_icode_o, W_valE_o, W_valM_o, W_dstE_o, W_dstM_o}),
                 192'(saved_w));
    end

    applyStimulus(4'h8, 0, 64'h40, 64'hCAFE, 4'h4, 4'hF, 3'd1, 1, 0, 0);
    step("call_bubbled");
    checkValue("bubble icode", 192'(M_icode_o), 192'(4'h1));
    applyStimulus(4'h5, 0, 64'h40, 0, 4'hF, 4'h3, 3'd1, 0, 0, 0);
    step("ld_after_bubble");

    applyStimulus(4'h4, 0, 64'h20, 64'hDEAD_BEEF_0BAD_F00D, 4'hF, 4'hF, 3'd1, 0, 0, 0);
    step("st_0x20");
    applyStimulus(4'h1, 0, 0, 0, 4'hF, 4'hF, 3'd1, 0, 0, 1);
    step("rst_mid_store");
    applyStimulus(4'h5, 0, 64'h20, 0, 4'hF, 4'h3, 3'd1, 0, 0, 0);
    step("ld_0x20");
    step("ld_0x20_w");

    for (int n = 0; n < 600; n++) begin
      applyStimulus(4'($urandom_range(0, 11)), 1'($urandom()), randAddr(), randAddr(),
                    4'($urandom()), 4'($urandom()), 3'($urandom_range(1, 4)),
                    $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 49) == 0);
      step("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
